// File: rtl/ramb16_s1_port_arbiter.sv
// Two-requester round-robin arbiter for one port of a 16K x 1 block RAM,
// with a sequential full-memory clear engine sharing the same RAM port.
module ramb16_s1_port_arbiter #(
  parameter bit CLR_ON_RESET = 1'b1,
  parameter bit CLR_VAL_DEF  = 1'b0
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        REQ0,
  input  logic        REQ1,
  input  logic        WE0,
  input  logic        WE1,
  input  logic [13:0] ADDR0,
  input  logic [13:0] ADDR1,
  input  logic        DI0,
  input  logic        DI1,
  output logic        GNT0,
  output logic        GNT1,
  output logic        RVALID0,
  output logic        RVALID1,
  output logic        RDATA0,
  output logic        RDATA1,
  input  logic        CLR_REQ,
  input  logic        CLR_VAL,
  output logic        BUSY,
  output logic        RAM_EN,
  output logic        RAM_WE,
  output logic        RAM_SSR,
  output logic [13:0] RAM_ADDR,
  output logic        RAM_DI,
  input  logic        RAM_DO
);

  localparam int unsigned AW = 14;
  localparam logic [AW-1:0] LAST_ADDR = '1;

  typedef enum logic {IDLE, CLEAR} state_e;

  typedef struct packed {
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic          di;
  } ram_cmd_t;

  state_e        state_q, state_d;
  logic          prio_q, prio_d;        // 0: requester 0 wins a tie
  logic          rst_clr_q;             // first cycle after reset acts as a clear request
  logic          clr_val_q, clr_val_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  ram_cmd_t      ram_q, ram_d;
  logic [1:0]    rd_pend_q, rd_pend_d;  // read issued to RAM this cycle
  logic [1:0]    rvalid_q;

  logic clr_start_c;
  logic arb_en_c;
  logic gnt0_c;
  logic gnt1_c;

  // Grant decode: a clear start blocks arbitration in its own cycle.
  always_comb begin
    clr_start_c = (state_q == IDLE) && (CLR_REQ || rst_clr_q);
    arb_en_c    = RSTN && (state_q == IDLE) && !clr_start_c;
    gnt0_c      = arb_en_c && REQ0 && (!REQ1 || !prio_q);
    gnt1_c      = arb_en_c && REQ1 && (!REQ0 ||  prio_q);
  end

  // Next-state, RAM command and pointer update.
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    clr_val_d = clr_val_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    ram_d     = '0;
    rd_pend_d = {gnt1_c && !WE1, gnt0_c && !WE0};

    case (state_q)
      IDLE: begin
        if (clr_start_c) begin
          state_d   = CLEAR;
          cnt_d     = '0;
          busy_d    = 1'b1;
          clr_val_d = rst_clr_q ? CLR_VAL_DEF : CLR_VAL;
        end else if (gnt0_c) begin
          ram_d.en   = 1'b1;
          ram_d.we   = WE0;
          ram_d.addr = ADDR0;
          ram_d.di   = DI0;
          prio_d     = 1'b1;
        end else if (gnt1_c) begin
          ram_d.en   = 1'b1;
          ram_d.we   = WE1;
          ram_d.addr = ADDR1;
          ram_d.di   = DI1;
          prio_d     = 1'b0;
        end
      end
      CLEAR: begin
        ram_d.en   = 1'b1;
        ram_d.we   = 1'b1;
        ram_d.addr = cnt_q;
        ram_d.di   = clr_val_q;
        cnt_d      = cnt_q + AW'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      rst_clr_q <= CLR_ON_RESET;
      clr_val_q <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      ram_q     <= '0;
      rd_pend_q <= '0;
      rvalid_q  <= '0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      rst_clr_q <= 1'b0;
      clr_val_q <= clr_val_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      ram_q     <= ram_d;
      rd_pend_q <= rd_pend_d;
      rvalid_q  <= rd_pend_q;
    end
  end

  assign GNT0     = gnt0_c;
  assign GNT1     = gnt1_c;
  assign RVALID0  = rvalid_q[0];
  assign RVALID1  = rvalid_q[1];
  // RAM_DO is valid in the strobe cycle; masked so it reads 0 otherwise.
  assign RDATA0   = rvalid_q[0] && RAM_DO;
  assign RDATA1   = rvalid_q[1] && RAM_DO;
  assign BUSY     = busy_q;
  assign RAM_EN   = ram_q.en;
  assign RAM_WE   = ram_q.we;
  assign RAM_ADDR = ram_q.addr;
  assign RAM_DI   = ram_q.di;
  assign RAM_SSR  = 1'b0;

endmodule

// File: tb/tb_ramb16_s1_port_arbiter.sv
// Directed bench for ramb16_s1_port_arbiter with a behavioural 16K x 1 RAM.
module tb_ramb16_s1_port_arbiter;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        REQ0, REQ1, WE0, WE1, DI0, DI1;
  logic [13:0] ADDR0, ADDR1;
  logic        GNT0, GNT1, RVALID0, RVALID1, RDATA0, RDATA1;
  logic        CLR_REQ, CLR_VAL, BUSY;
  logic        RAM_EN, RAM_WE, RAM_SSR, RAM_DI;
  logic [13:0] RAM_ADDR;
  logic        RAM_DO = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  ramb16_s1_port_arbiter dut (
    .CLK(CLK), .RSTN(RSTN),
    .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .DI0(DI0), .DI1(DI1),
    .GNT0(GNT0), .GNT1(GNT1), .RVALID0(RVALID0), .RVALID1(RVALID1),
    .RDATA0(RDATA0), .RDATA1(RDATA1),
    .CLR_REQ(CLR_REQ), .CLR_VAL(CLR_VAL), .BUSY(BUSY),
    .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_SSR(RAM_SSR),
    .RAM_ADDR(RAM_ADDR), .RAM_DI(RAM_DI), .RAM_DO(RAM_DO)
  );

  // Behavioural RAM: write-first not needed, read data one cycle after sampling.
  logic mem [16384];
  initial for (int k = 0; k < 16384; k++) mem[k] = 1'b0;
  always @(posedge CLK) begin
    if (RAM_EN && RAM_WE)  mem[RAM_ADDR] <= RAM_DI;
    if (RAM_EN && !RAM_WE) RAM_DO <= mem[RAM_ADDR];
  end

  logic [24:0] all_out;
  assign all_out = {GNT0, GNT1, RVALID0, RVALID1, RDATA0, RDATA1, BUSY,
                    RAM_EN, RAM_WE, RAM_DI, RAM_SSR, RAM_ADDR};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic smp;
    @(negedge CLK);
  endtask

  // Called at the sample point of the clear-trigger cycle; returns at the
  // sample point of the first cycle with BUSY low.
  task automatic run_clear(input string tag, input logic val,
                           output logic rv0_first, output logic rd0_first);
    int          busy_cnt = 0;
    int          wr_cnt   = 0;
    int          bad      = 0;
    int          gnt_seen = 0;
    logic [13:0] exp_a    = '0;
    bit          done     = 1'b0;
    rv0_first = 1'b0;
    rd0_first = 1'b0;
    for (int i = 1; i <= 17000 && !done; i++) begin
      tick;
      CLR_REQ = (i == 50);
      CLR_VAL = (i == 50) ? ~val : val;
      smp;
      if (i == 1) begin
        rv0_first = RVALID0;
        rd0_first = RDATA0;
      end
      if (BUSY) begin
        busy_cnt++;
        if (GNT0 || GNT1) gnt_seen++;
      end else begin
        done = 1'b1;
      end
      if (RAM_EN) begin
        if (!RAM_WE || RAM_DI !== val || RAM_ADDR !== exp_a) bad++;
        exp_a++;
        wr_cnt++;
      end
    end
    CLR_REQ = 1'b0;
    chk({tag, "_done"},     32'(done), 1);
    chk({tag, "_busy_len"}, 32'(busy_cnt), 16384);
    chk({tag, "_wr_cnt"},   32'(wr_cnt), 16384);
    chk({tag, "_wr_bad"},   32'(bad), 0);
    chk({tag, "_gnt"},      32'(gnt_seen), 0);
  endtask

  logic [1:0] exp_g  [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
  logic [3:0] exp_rv [4] = '{4'b1010, 4'b0101, 4'b1010, 4'b0101};
  logic rv0, rd0;
  bit   found;

  initial begin
    RSTN = 1'b0; REQ0 = 1'b1; REQ1 = 1'b0; WE0 = 1'b0; WE1 = 1'b0;
    ADDR0 = 14'h0004; ADDR1 = '0; DI0 = 1'b0; DI1 = 1'b0;
    CLR_REQ = 1'b0; CLR_VAL = 1'b0;

    // Reset: every output low, grant masked although REQ0 is high.
    tick; smp;
    tick; smp; chk("rst_outs_a", 32'(all_out), 0);
    tick; smp; chk("rst_outs_b", 32'(all_out), 0);

    // First cycle out of reset acts as a clear request.
    tick; RSTN = 1'b1; smp;
    chk("rel_gnt_busy", 32'({GNT0, GNT1, BUSY}), 0);
    run_clear("rclr", 1'b0, rv0, rd0);
    chk("rclr_rv0_first", 32'(rv0), 0);
    chk("rclr_exit_gnt", 32'({GNT0, GNT1}), 32'(2'b10));
    tick; REQ0 = 1'b0; smp;
    tick; smp; chk("rclr_rd4", 32'({RVALID0, RDATA0}), 32'(2'b10));

    // Writes: REQ0 writes 1 to 0x0005, then REQ1 writes 1 to 0x3FFF.
    tick; REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 14'h0005; DI0 = 1'b1; smp;
    chk("wr0_gnt", 32'(GNT0), 1);
    tick; REQ0 = 1'b0; REQ1 = 1'b1; WE1 = 1'b1; ADDR1 = 14'h3FFF; DI1 = 1'b1; smp;
    chk("wr0_pins", 32'({RAM_EN, RAM_WE, RAM_DI, RAM_ADDR}), 32'({3'b111, 14'h0005}));
    chk("wr1_gnt", 32'(GNT1), 1);
    tick; REQ1 = 1'b0; WE0 = 1'b0; WE1 = 1'b0; DI0 = 1'b0; DI1 = 1'b0; smp;
    chk("wr1_pins", 32'({RAM_EN, RAM_WE, RAM_DI, RAM_ADDR}), 32'({3'b111, 14'h3FFF}));
    chk("wr0_no_rvalid", 32'(RVALID0), 0);
    tick; smp;
    chk("wr1_no_rvalid_idle", 32'({RVALID1, RAM_EN}), 0);

    // Single read of 0x0005 by requester 0: latency 2.
    tick; REQ0 = 1'b1; ADDR0 = 14'h0005; smp;
    chk("rd0_gnt", 32'(GNT0), 1);
    tick; REQ0 = 1'b0; smp;
    chk("rd0_pins", 32'({RAM_EN, RAM_WE, RAM_ADDR, RVALID0}), 32'({2'b10, 14'h0005, 1'b0}));
    tick; smp; chk("rd0_data", 32'({RVALID0, RDATA0}), 32'(2'b11));
    tick; smp; chk("rd0_strobe_end", 32'(RVALID0), 0);

    // Back-to-back reads by requester 1: 0x3FFF (1) then 0x0004 (0).
    tick; REQ1 = 1'b1; ADDR1 = 14'h3FFF; smp; chk("b2b_gnt_a", 32'(GNT1), 1);
    tick; ADDR1 = 14'h0004; smp;             chk("b2b_gnt_b", 32'(GNT1), 1);
    tick; REQ1 = 1'b0; smp; chk("b2b_data_a", 32'({RVALID1, RDATA1}), 32'(2'b11));
    tick; smp;              chk("b2b_data_b", 32'({RVALID1, RDATA1}), 32'(2'b10));
    tick; smp;              chk("b2b_end", 32'(RVALID1), 0);

    // Both requesting for 4 cycles: alternating grants and returns.
    for (int i = 0; i < 6; i++) begin
      tick;
      REQ0 = (i < 4); REQ1 = (i < 4); ADDR0 = 14'h0005; ADDR1 = 14'h3FFF;
      smp;
      if (i < 4)  chk("rr_gnt", 32'({GNT0, GNT1}), 32'(exp_g[i]));
      if (i >= 2) chk("rr_rv",  32'({RVALID0, RVALID1, RDATA0, RDATA1}), 32'(exp_rv[i-2]));
    end

    // Read in flight, then clear (value 1) colliding with requests.
    tick; REQ0 = 1'b1; ADDR0 = 14'h0005; smp; chk("pre_clr_gnt", 32'(GNT0), 1);
    tick; CLR_REQ = 1'b1; CLR_VAL = 1'b1; ADDR0 = 14'h0004; REQ1 = 1'b1; ADDR1 = 14'h0004; smp;
    chk("clr_req_gnt", 32'({GNT0, GNT1, BUSY}), 0);
    run_clear("uclr", 1'b1, rv0, rd0);
    chk("uclr_inflight_rd", 32'({rv0, rd0}), 32'(2'b11));
    chk("uclr_exit_gnt", 32'({GNT0, GNT1}), 32'(2'b01));
    tick; REQ0 = 1'b0; REQ1 = 1'b0; smp;
    chk("uclr_rd_pins", 32'({RAM_EN, RAM_WE, RAM_ADDR}), 32'({2'b10, 14'h0004}));
    tick; smp; chk("uclr_rd4", 32'({RVALID1, RDATA1}), 32'(2'b11));

    // Reset in the middle of a clear: abort, then restart from 0 with value 0.
    tick; CLR_REQ = 1'b1; CLR_VAL = 1'b1; smp;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick; CLR_REQ = 1'b0; smp;
      if (RAM_EN && RAM_ADDR == 14'd100) found = 1'b1;
    end
    chk("mid_found_100", 32'(found), 1);
    tick; RSTN = 1'b0; REQ0 = 1'b1; ADDR0 = 14'h0004; smp;
    tick; smp; chk("mid_rst_outs_a", 32'(all_out), 0);
    tick; smp; chk("mid_rst_outs_b", 32'(all_out), 0);
    tick; RSTN = 1'b1; smp;
    chk("mid_rel_gnt_busy", 32'({GNT0, GNT1, BUSY}), 0);
    run_clear("mclr", 1'b0, rv0, rd0);
    chk("mclr_rv0_first", 32'(rv0), 0);
    chk("mclr_exit_gnt", 32'({GNT0, GNT1}), 32'(2'b10));
    tick; REQ0 = 1'b0; smp;
    tick; smp; chk("mclr_rd4", 32'({RVALID0, RDATA0}), 32'(2'b10));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
